// File: rtl/ro_scan_scheduler.sv
// Scan scheduler for the RO temperature sensor: select, settle, measure, latch, then frame out over UART.
// Optional: define ROSCAN_SEQNUM_EN to append an 8-bit frame sequence byte to every frame.
module ro_scan_scheduler #(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 16,
  parameter int WIN_CYCLES    = 1000,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     continuous,
  input  logic [N_CH-1:0]          ch_mask,
  input  logic [CNT_W-1:0]         cnt_value,
  input  logic                     tx_busy,
  output logic [$clog2(N_CH)-1:0]  ro_sel,
  output logic                     ro_en,
  output logic                     cnt_clr,
  output logic                     cnt_en,
  output logic                     tx_send,
  output logic [7:0]               tx_data,
  output logic                     busy,
  output logic                     done
);

  localparam int CH_W       = $clog2(N_CH);
  localparam int TMR_MAX    = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W      = $clog2(TMR_MAX + 1);
  localparam int DATA_BYTES = CNT_W / 8;
`ifdef ROSCAN_SEQNUM_EN
  localparam int FRAME_BYTES = DATA_BYTES + 2;
`else
  localparam int FRAME_BYTES = DATA_BYTES + 1;
`endif
  localparam int BYTE_W     = $clog2(FRAME_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, SETTLE, MEASURE, LATCH, SEND, WAIT_TX, NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [CNT_W-1:0]  sh_q, sh_d;
  logic [7:0]        cur_byte, tx_data_d;
  logic              tx_send_d, done_d;
  logic [CH_W:0]     nxt;
`ifdef ROSCAN_SEQNUM_EN
  logic [7:0]        seq_q, seq_d;
`endif

  function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] m);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (m[i]) r = CH_W'(i);
    return r;
  endfunction

  // MSB flags whether any enabled channel exists above cur.
  function automatic logic [CH_W:0] next_above(input logic [N_CH-1:0] m,
                                               input logic [CH_W-1:0] cur);
    logic [CH_W:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (m[i] && (i > int'(cur))) r = {1'b1, CH_W'(i)};
    return r;
  endfunction

  assign nxt = next_above(mask_q, idx_q);

  always_comb begin
    if (byte_q == '0) cur_byte = {4'hA, 4'(idx_q)};
`ifdef ROSCAN_SEQNUM_EN
    else if (byte_q == BYTE_W'(FRAME_BYTES - 1)) cur_byte = seq_q;
`endif
    else cur_byte = sh_q[CNT_W-1 -: 8];
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    tmr_d     = tmr_q;
    byte_d    = byte_q;
    sh_d      = sh_q;
    tx_data_d = tx_data;
    tx_send_d = 1'b0;
    done_d    = 1'b0;
`ifdef ROSCAN_SEQNUM_EN
    seq_d     = seq_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d = ch_mask;
          if (|ch_mask) begin
            idx_d   = lowest_set(ch_mask);
            state_d = SELECT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SELECT: begin
        tmr_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = MEASURE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      MEASURE: begin
        if (tmr_q == TMR_W'(WIN_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = LATCH;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      LATCH: begin
        sh_d    = cnt_value;
        byte_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_send_d = 1'b1;
          tx_data_d = cur_byte;
          tmr_d     = '0;
          state_d   = WAIT_TX;
          if (byte_q != '0) sh_d = sh_q << 8;
        end
      end
      // First cycle is unconditional so the transmitter has time to raise tx_busy.
      WAIT_TX: begin
        if (tmr_q == '0) begin
          tmr_d = TMR_W'(1);
        end else if (!tx_busy) begin
          if (byte_q == BYTE_W'(FRAME_BYTES - 1)) begin
            state_d = NEXT;
`ifdef ROSCAN_SEQNUM_EN
            seq_d   = seq_q + 8'd1;
`endif
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = SEND;
          end
        end
      end
      NEXT: begin
        if (nxt[CH_W]) begin
          idx_d   = nxt[CH_W-1:0];
          state_d = SELECT;
        end else if (continuous) begin
          idx_d   = lowest_set(mask_q);
          state_d = SELECT;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      ro_sel  <= '0;
      ro_en   <= 1'b0;
      cnt_clr <= 1'b0;
      cnt_en  <= 1'b0;
      tx_send <= 1'b0;
      tx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef ROSCAN_SEQNUM_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      ro_sel  <= idx_d;
      ro_en   <= (state_d == SELECT) || (state_d == SETTLE) ||
                 (state_d == MEASURE) || (state_d == LATCH);
      cnt_clr <= (state_d == SELECT);
      cnt_en  <= (state_d == MEASURE);
      tx_send <= tx_send_d;
      tx_data <= tx_data_d;
      busy    <= (state_d != IDLE);
      done    <= done_d;
`ifdef ROSCAN_SEQNUM_EN
      seq_q   <= seq_d;
`endif
    end
  end

endmodule
